// File: rtl/word_pick_ctrl.sv
// Word-index picker: strobes the RNG, filters out-of-range and recently issued
// indices, falls back to a linear scan, and hands the result over under valid/ack.
module word_pick_ctrl #(
    parameter int WORD_COUNT = 100,
    parameter int HIST_DEPTH = 8,
    parameter int RNG_LAT    = 2,
    parameter int MAX_RETRY  = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       new_word_req,
    input  logic       word_ack,
    input  logic       clear_history,
    input  logic [6:0] random_num,
    output logic       grab_word,
    output logic [6:0] word_idx,
    output logic       word_valid,
    output logic       busy,
    output logic       fallback_used
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GRAB,
        S_WAIT,
        S_CHECK,
        S_SCAN,
        S_PRESENT
    } state_t;

    localparam int RW = $clog2(MAX_RETRY + 2);
    localparam int WW = $clog2(RNG_LAT + 1);
    localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRY);
    localparam logic [WW-1:0] WAIT_LAST  = WW'(RNG_LAT - 1);
    localparam logic [7:0]    WC         = 8'(WORD_COUNT);
    localparam logic [6:0]    IDX_LAST   = 7'(WORD_COUNT - 1);

    state_t          state, state_next;
    logic [RW-1:0]   retry_cnt;
    logic [WW-1:0]   wait_cnt;
    logic [6:0]      scan_idx;
    logic            hist_vld [HIST_DEPTH];
    logic [6:0]      hist_idx [HIST_DEPTH];

    logic            rng_hit, scan_hit, rng_in_range, rng_accept;
    logic            push_en;
    logic [6:0]      push_idx;
    logic            grab_d, valid_d, busy_d;

    // Candidate qualification against the live history entries.
    always_comb begin
        rng_hit  = 1'b0;
        scan_hit = 1'b0;
        for (int i = 0; i < HIST_DEPTH; i++) begin
            if (hist_vld[i] && (hist_idx[i] == random_num)) rng_hit  = 1'b1;
            if (hist_vld[i] && (hist_idx[i] == scan_idx))   scan_hit = 1'b1;
        end
        rng_in_range = ({1'b0, random_num} < WC);
        rng_accept   = rng_in_range && !rng_hit;
        push_en      = ((state == S_CHECK) && rng_accept) ||
                       ((state == S_SCAN) && !scan_hit);
        push_idx     = (state == S_SCAN) ? scan_idx : random_num;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:    if (new_word_req) state_next = S_GRAB;
            S_GRAB:    state_next = S_WAIT;
            S_WAIT:    if (wait_cnt == WAIT_LAST) state_next = S_CHECK;
            S_CHECK: begin
                if (rng_accept)                    state_next = S_PRESENT;
                else if (retry_cnt == RETRY_LAST)  state_next = S_SCAN;
                else                               state_next = S_GRAB;
            end
            S_SCAN:    if (!scan_hit) state_next = S_PRESENT;
            S_PRESENT: if (word_ack) state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they register in step with it.
    always_comb begin
        grab_d  = (state_next == S_GRAB);
        valid_d = (state_next == S_PRESENT);
        busy_d  = (state_next != S_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grab_word     <= 1'b0;
            word_valid    <= 1'b0;
            busy          <= 1'b0;
            word_idx      <= '0;
            fallback_used <= 1'b0;
            retry_cnt     <= '0;
            wait_cnt      <= '0;
            scan_idx      <= '0;
        end else begin
            grab_word  <= grab_d;
            word_valid <= valid_d;
            busy       <= busy_d;
            if (push_en) word_idx <= push_idx;

            if ((state == S_IDLE) && new_word_req) begin
                retry_cnt     <= '0;
                fallback_used <= 1'b0;
            end else if ((state == S_CHECK) && !rng_accept && (retry_cnt != RETRY_LAST)) begin
                retry_cnt <= retry_cnt + 1'b1;
            end else if ((state == S_SCAN) && !scan_hit) begin
                fallback_used <= 1'b1;
            end

            if (state == S_GRAB)
                wait_cnt <= '0;
            else if ((state == S_WAIT) && (wait_cnt != WAIT_LAST))
                wait_cnt <= wait_cnt + 1'b1;

            // Scan starts from the last rejected sample when it is at least in range.
            if ((state == S_CHECK) && !rng_accept && (retry_cnt == RETRY_LAST))
                scan_idx <= rng_in_range ? random_num : 7'd0;
            else if ((state == S_SCAN) && scan_hit)
                scan_idx <= (scan_idx == IDX_LAST) ? 7'd0 : scan_idx + 7'd1;
        end
    end

    // History shift register; a clear in the same cycle as a push keeps only the new entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < HIST_DEPTH; i++) begin
                hist_vld[i] <= 1'b0;
                hist_idx[i] <= '0;
            end
        end else if (clear_history) begin
            for (int i = 0; i < HIST_DEPTH; i++) hist_vld[i] <= 1'b0;
            if (push_en) begin
                hist_vld[0] <= 1'b1;
                hist_idx[0] <= push_idx;
            end
        end else if (push_en) begin
            for (int i = HIST_DEPTH - 1; i > 0; i--) begin
                hist_vld[i] <= hist_vld[i-1];
                hist_idx[i] <= hist_idx[i-1];
            end
            hist_vld[0] <= 1'b1;
            hist_idx[0] <= push_idx;
        end
    end

endmodule

// File: tb/tb_word_pick_ctrl.sv
// Directed bench for word_pick_ctrl: the bench plays the RNG from a per-request
// sequence table and checks latency, pulse counts, indices and flags.
module tb_word_pick_ctrl;

    logic       clk;
    logic       reset;
    logic       new_word_req;
    logic       word_ack;
    logic       clear_history;
    logic [6:0] random_num;
    logic       grab_word;
    logic [6:0] word_idx;
    logic       word_valid;
    logic       busy;
    logic       fallback_used;

    int vectors;
    int miscompares;

    logic [6:0] rng_seq [0:7];
    int         lat, grabs;
    logic       g0, g1, b0, fb0;

    word_pick_ctrl #(
        .WORD_COUNT(100),
        .HIST_DEPTH(8),
        .RNG_LAT(2),
        .MAX_RETRY(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .new_word_req(new_word_req),
        .word_ack(word_ack),
        .clear_history(clear_history),
        .random_num(random_num),
        .grab_word(grab_word),
        .word_idx(word_idx),
        .word_valid(word_valid),
        .busy(busy),
        .fallback_used(fallback_used)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Request a word; the n-th grab pulse loads rng_seq[n-1] (last entry repeats).
    task automatic do_request(input int n_vals);
        int k;
        lat   = 0;
        grabs = 0;
        g1    = 1'b0;
        @(negedge clk);
        new_word_req = 1'b1;
        @(posedge clk); #1;
        new_word_req = 1'b0;
        g0  = grab_word;
        b0  = busy;
        fb0 = fallback_used;
        while ((word_valid !== 1'b1) && (lat < 200)) begin
            if (lat == 1) g1 = grab_word;
            if (grab_word === 1'b1) begin
                grabs++;
                k = (grabs - 1 < n_vals) ? grabs - 1 : n_vals - 1;
                random_num = rng_seq[k];
            end
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic ack_word(input logic with_req);
        @(negedge clk);
        word_ack     = 1'b1;
        new_word_req = with_req;
        @(posedge clk); #1;
        word_ack     = 1'b0;
        new_word_req = 1'b0;
    endtask

    task automatic issue(input logic [6:0] v);
        rng_seq[0] = v;
        do_request(1);
        check("issue_idx", word_idx, v);
        ack_word(1'b0);
    endtask

    initial begin
        vectors       = 0;
        miscompares   = 0;
        reset         = 1'b1;
        new_word_req  = 1'b0;
        word_ack      = 1'b0;
        clear_history = 1'b0;
        random_num    = 7'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_grab",  grab_word, 0);
        check("rst_valid", word_valid, 0);
        check("rst_busy",  busy, 0);
        check("rst_idx",   word_idx, 0);
        check("rst_fb",    fallback_used, 0);
        @(negedge clk);
        reset = 1'b0;

        // Basic request: 37 accepted first try.
        rng_seq[0] = 7'd37;
        do_request(1);
        check("basic_grab_e0", g0, 1);
        check("basic_grab_e1", g1, 0);
        check("basic_busy_e0", b0, 1);
        check("basic_lat",     lat, 4);
        check("basic_grabs",   grabs, 1);
        check("basic_idx",     word_idx, 37);
        check("basic_fb",      fallback_used, 0);
        repeat (2) @(posedge clk);
        #1;
        check("basic_hold_valid", word_valid, 1);
        check("basic_hold_busy",  busy, 1);
        ack_word(1'b1);
        check("basic_ack_valid", word_valid, 0);
        check("basic_ack_busy",  busy, 0);
        @(posedge clk); #1;
        check("basic_req_ignored_busy", busy, 0);
        check("basic_req_ignored_grab", grab_word, 0);

        // Out-of-range sample rejected.
        rng_seq[0] = 7'd120;
        rng_seq[1] = 7'd12;
        do_request(2);
        check("oor_lat",   lat, 8);
        check("oor_grabs", grabs, 2);
        check("oor_idx",   word_idx, 12);
        check("oor_fb",    fallback_used, 0);
        ack_word(1'b0);

        // Duplicate rejected; then both 6 and 5 are in history.
        issue(7'd5);
        rng_seq[0] = 7'd5;
        rng_seq[1] = 7'd6;
        do_request(2);
        check("dup_grabs", grabs, 2);
        check("dup_idx",   word_idx, 6);
        ack_word(1'b0);
        rng_seq[0] = 7'd6;
        rng_seq[1] = 7'd5;
        rng_seq[2] = 7'd9;
        do_request(3);
        check("dup_hist_grabs", grabs, 3);
        check("dup_hist_idx",   word_idx, 9);
        ack_word(1'b0);

        // Fallback scan: 10,11,12 in history, RNG stuck at 10.
        issue(7'd10);
        issue(7'd11);
        rng_seq[0] = 7'd10;
        do_request(1);
        check("fb_grabs", grabs, 5);
        check("fb_lat",   lat, 24);
        check("fb_idx",   word_idx, 13);
        check("fb_flag",  fallback_used, 1);
        ack_word(1'b0);

        // Scan wraps past WORD_COUNT-1; first request also clears the fallback flag.
        rng_seq[0] = 7'd99;
        do_request(1);
        check("wrap_fb_cleared", fb0, 0);
        check("wrap_issue99",    word_idx, 99);
        ack_word(1'b0);
        issue(7'd0);
        rng_seq[0] = 7'd99;
        do_request(1);
        check("wrap_grabs", grabs, 5);
        check("wrap_lat",   lat, 23);
        check("wrap_idx",   word_idx, 1);
        check("wrap_fb",    fallback_used, 1);
        ack_word(1'b0);

        // clear_history lets a just-issued index through again.
        issue(7'd20);
        @(negedge clk);
        clear_history = 1'b1;
        @(posedge clk); #1;
        clear_history = 1'b0;
        check("clr_busy", busy, 0);
        rng_seq[0] = 7'd20;
        rng_seq[1] = 7'd21;
        do_request(2);
        check("clr_grabs", grabs, 1);
        check("clr_idx",   word_idx, 20);
        ack_word(1'b0);

        // Reset in WAIT: outputs drop immediately, history is wiped.
        @(negedge clk);
        new_word_req = 1'b1;
        @(posedge clk); #1;
        new_word_req = 1'b0;
        random_num   = 7'd44;
        @(posedge clk); #1;
        check("rstw_busy_pre", busy, 1);
        reset = 1'b1;
        #1;
        check("rstw_grab",  grab_word, 0);
        check("rstw_valid", word_valid, 0);
        check("rstw_busy",  busy, 0);
        @(negedge clk);
        reset = 1'b0;
        rng_seq[0] = 7'd20;
        do_request(1);
        check("post_rst_grab_e0", g0, 1);
        check("post_rst_lat",     lat, 4);
        check("post_rst_grabs",   grabs, 1);
        check("post_rst_idx",     word_idx, 20);
        check("post_rst_fb",      fallback_used, 0);
        ack_word(1'b0);
        check("post_rst_ack_valid", word_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/word_pick_ctrl.md
Name: word_pick_ctrl

Overview:
- Sequencing controller for the 7-bit random number generator in the word-game datapath.
- On a request from game logic, pulses the RNG's grab_word strobe, waits out RNG latency, then samples random_num.
- Rejects out-of-range or recently used indices and retries. Falls back to a deterministic linear scan after too many rejects.
- Presents a unique word index to the game FSM under a valid/ack handshake.

Parameters:
- WORD_COUNT, 100: number of valid word-list entries; legal indices are 0..WORD_COUNT-1. Constraint: HIST_DEPTH < WORD_COUNT <= 128.
- HIST_DEPTH, 8: number of most recently issued indices that may not be reissued.
- RNG_LAT, 2: clk cycles from the grab_word pulse until random_num is stable. Constraint: >= 1.
- MAX_RETRY, 4: rejected RNG samples tolerated before the fallback scan.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high; clears all state
- new_word_req  in  1  request for a new word index; sampled only in IDLE
- word_ack  in  1  consumer accepts word_idx; meaningful only while word_valid=1
- clear_history  in  1  synchronous new-game clear of the history buffer
- random_num  in  7  RNG output
- grab_word  out  1  one-cycle strobe to the RNG
- word_idx  out  7  issued word index
- word_valid  out  1  word_idx is valid; held until acknowledged
- busy  out  1  high in every state except IDLE
- fallback_used  out  1  set when the current word_idx came from the scan; cleared on the next request

Behaviour:
- Reset values (asynchronous): state=IDLE, grab_word=0, word_idx=0, word_valid=0, fallback_used=0, retry count=0, all history entries invalid.
- All outputs are registered.
- State machine:
  - IDLE: on new_word_req=1, go to GRAB, zero the retry count, clear fallback_used.
  - GRAB: grab_word=1 for exactly this one cycle, then go to WAIT.
  - WAIT: stay RNG_LAT cycles with grab_word=0, then go to CHECK.
  - CHECK: candidate = random_num. Reject if candidate >= WORD_COUNT or candidate equals any valid history entry.
    - Accept: go to PRESENT.
    - Reject with retry count < MAX_RETRY: increment the count, go to GRAB.
    - Reject with retry count = MAX_RETRY: go to SCAN. Scan start = candidate if < WORD_COUNT, else 0.
  - SCAN: one candidate per cycle. If the candidate is not in history, accept and set fallback_used=1. Otherwise candidate = (candidate+1) wraps to 0 at WORD_COUNT. Terminates in <= HIST_DEPTH+1 cycles because HIST_DEPTH < WORD_COUNT.
  - PRESENT: word_valid=1, word_idx stable. On word_ack=1, word_valid drops at the next edge and the state returns to IDLE.
- Latency, no retry: new_word_req sampled at edge E0; grab_word high E0..E1; word_valid rises at edge E0+2+RNG_LAT (E4 at defaults). Each retry adds 2+RNG_LAT cycles.
- History:
  - Shift register of {valid, idx}. The accepted index is pushed at the same edge word_valid rises; the oldest entry is dropped.
  - Matching is against entries with valid=1 only.
- clear_history:
  - Invalidates all entries at the next edge.
  - If it coincides with a push, the clear wins, then the push is applied: the entry just issued is the sole valid entry.
  - Does not change the FSM state.
- new_word_req outside IDLE is ignored, not queued. new_word_req in the same cycle as word_ack is ignored, since the state is PRESENT. busy=1 tells the requester to hold off.
- word_ack while word_valid=0 is ignored.
- random_num is sampled only in CHECK. Its value in any other state is don't-care.
- Reset mid-operation (any state) returns to IDLE immediately. A grab_word pulse in flight is cut. History is cleared.

Test Plan:
- Basic request: RNG model returns 37, RNG_LAT=2. Pulse new_word_req at E0 -> grab_word high one cycle after E0; word_idx=37, word_valid=1 at E4; busy=1 from E0 to ack; valid stays high until word_ack, then busy=0 one edge later.
- Out-of-range reject: RNG returns 120 then 12 (WORD_COUNT=100) -> two grab_word pulses; word_idx=12; valid at E0+8; fallback_used=0.
- Duplicate reject: issue and ack 5. Next request, RNG returns 5 then 6 -> 5 is rejected, word_idx=6; the history now holds 5 and 6.
- Fallback: history holds 10,11,12. RNG returns 10 on all 5 samples (MAX_RETRY=4) -> SCAN checks 10,11,12,13; word_idx=13; fallback_used=1; exactly 5 grab_word pulses.
- Scan wrap: WORD_COUNT=100, history holds 99 and 0. RNG returns 99 five times -> word_idx=1 (99 -> 0 -> 1).
- Clear and reset: issue and ack 20, then assert clear_history one cycle. RNG returns 20 -> accepted first try. Assert reset during WAIT -> grab_word=0, word_valid=0, busy=0 immediately. A following request behaves like the basic-request case.
